// File: rtl/rca14_rr_sched.sv
// rca14_rr_sched: round-robin scheduler that shares one 14-bit ripple-carry
// adder among NREQ requesters. The adder runs from registered operands, and the
// result is returned with its owner's ID over a valid/ready response port.
//
// state | meaning
// IDLE  | no work in flight, grants allowed
// CALC  | operands latched, adder settling, no grants
// DONE  | result presented; retires on rsp_ready, which also reopens grants
module rca14_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*14-1:0]   req_a,
  input  logic [NREQ*14-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [13:0]          rsp_sum,
  output logic                 rsp_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] rr_ptr;
  logic [13:0]    op_a, op_b;
  logic           op_cin;
  logic [IDW-1:0] op_id;

  logic            accept_ok;
  logic            found;
  logic            hs;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic [13:0]     sel_a, sel_b;
  logic            sel_cin;
  logic [13:0]     add_sum;
  logic            add_cout;

  // Round-robin search starting one past the last winner, wrapping at NREQ.
  always_comb begin
    int t;
    logic [IDW-1:0] idx;
    t        = 0;
    idx      = '0;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      t = int'(rr_ptr) + 1 + k;
      if (t >= NREQ) t = t - NREQ;
      idx = IDW'(t);
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a   = req_a[14*i +: 14];
        sel_b   = req_b[14*i +: 14];
        sel_cin = req_cin[i];
      end
    end
  end

  // Grants open in IDLE, or in DONE on the cycle the result is being taken.
  always_comb begin
    accept_ok = rst_n && ((state == IDLE) || ((state == DONE) && rsp_ready));
    req_ready = accept_ok ? grant : '0;
    hs        = accept_ok && found;
  end

  // 14-bit ripple-carry chain on the registered operands.
  always_comb begin
    logic c;
    c       = op_cin;
    add_sum = '0;
    for (int i = 0; i < 14; i++) begin
      add_sum[i] = op_a[i] ^ op_b[i] ^ c;
      c          = (op_a[i] & op_b[i]) | (c & (op_a[i] ^ op_b[i]));
    end
    add_cout = c;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hs) state_nx = CALC;
      CALC:    state_nx = DONE;
      DONE:    if (rsp_ready) state_nx = hs ? CALC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Operand capture, arbitration pointer and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= IDW'(NREQ - 1);
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      if (hs) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        op_cin <= sel_cin;
        op_id  <= grant_id;
        rr_ptr <= grant_id;
      end
      if (state == CALC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= op_id;
        rsp_sum   <= add_sum;
        rsp_cout  <= add_cout;
      end else if ((state == DONE) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rca14_rr_sched.sv
// Bench for rca14_rr_sched: directed scenarios followed by random traffic, all
// checked each cycle against a transaction-level model of the scheduler.
module tb_rca14_rr_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*14-1:0]   req_a;
  logic [NREQ*14-1:0]   req_b;
  logic [NREQ-1:0]      req_cin;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [13:0]          rsp_sum;
  logic                 rsp_cout;

  rca14_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Transaction model: one job outstanding at most; a job granted on an edge
  // becomes visible one edge later and stays until taken with rsp_ready.
  int          rr_last = NREQ - 1;
  bit          busy    = 1'b0;
  int          age     = 0;
  int          t_id    = 0;
  logic [14:0] t_res   = '0;
  int          shown_id  = 0;
  logic [14:0] shown_res = '0;
  bit          keep_valid = 1'b0;
  logic [NREQ-1:0] ready_seen;
  int          obs_ids[$];
  int          exp_seq[6] = '{0, 1, 2, 3, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] rand_op();
    int s;
    s = $urandom_range(0, 3);
    if (s == 0) return 14'h3FFF;
    if (s == 1) return 14'h0000;
    return 14'($urandom_range(0, 16383));
  endfunction

  task automatic set_req(input int i, input logic [13:0] a, input logic [13:0] b, input logic c);
    req_a[14*i +: 14] = a;
    req_b[14*i +: 14] = b;
    req_cin[i]        = c;
    req_valid[i]      = 1'b1;
  endtask

  // One clock: check outputs against the model, advance the model across the
  // coming edge, then return at the next falling edge.
  task automatic cycle();
    int g;
    bit ev;
    bit acc;
    logic [NREQ-1:0] eg;
    #1;
    ev = busy && (age >= 1);
    if (ev) begin
      shown_id  = t_id;
      shown_res = t_res;
    end
    acc = rst_n && (!busy || (ev && rsp_ready));
    g = -1;
    if (acc) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (g < 0 && req_valid[(rr_last + k) % NREQ]) g = (rr_last + k) % NREQ;
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    ready_seen = req_ready;
    chk("req_ready", 32'(req_ready), 32'(eg));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("rsp_id",    32'(rsp_id),    32'(shown_id));
    chk("rsp_sum",   32'(rsp_sum),   32'(shown_res[13:0]));
    chk("rsp_cout",  32'(rsp_cout),  32'(shown_res[14]));
    if (!rst_n) begin
      busy      = 1'b0;
      age       = 0;
      rr_last   = NREQ - 1;
      shown_id  = 0;
      shown_res = '0;
    end else begin
      if (ev && rsp_ready) begin
        obs_ids.push_back(int'(rsp_id));
        busy = 1'b0;
      end else if (busy) begin
        age++;
      end
      if (g >= 0) begin
        busy    = 1'b1;
        age     = 0;
        rr_last = g;
        t_id    = g;
        t_res   = 15'(req_a[14*g +: 14]) + 15'(req_b[14*g +: 14]) + 15'(req_cin[g]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (g >= 0 && !keep_valid) req_valid[g] = 1'b0;
  endtask

  task automatic rand_inputs();
    rsp_ready = ($urandom_range(0, 3) != 0);
    rst_n     = ($urandom_range(0, 149) != 0);
    for (int i = 0; i < NREQ; i++) begin
      if (!req_valid[i]) begin
        if ($urandom_range(0, 2) == 0) set_req(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 31) == 0) begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    @(negedge clk);

    // T1: reset held two clocks with every requester valid.
    for (int i = 0; i < NREQ; i++) set_req(i, rand_op(), rand_op(), 1'b1);
    #1;
    chk("t1_ready_in_reset", 32'(req_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    cycle();
    #1;
    chk("t1_ready", 32'(req_ready), 32'h0);
    chk("t1_valid", 32'(rsp_valid), 32'h0);
    chk("t1_id",    32'(rsp_id),    32'h0);
    chk("t1_sum",   32'(rsp_sum),   32'h0);
    chk("t1_cout",  32'(rsp_cout),  32'h0);
    rst_n     = 1'b1;
    req_valid = '0;

    // T2: single operation from requester 1.
    set_req(1, 14'h1234, 14'h0F0F, 1'b1);
    cycle();
    chk("t2_grant", 32'(ready_seen), 32'h2);
    cycle();
    #1;
    chk("t2_valid", 32'(rsp_valid), 32'h1);
    chk("t2_id",    32'(rsp_id),    32'h1);
    chk("t2_sum",   32'(rsp_sum),   32'h2144);
    chk("t2_cout",  32'(rsp_cout),  32'h0);
    cycle();

    // T3: full-scale overflow from requester 0.
    set_req(0, 14'h3FFF, 14'h3FFF, 1'b1);
    cycle();
    cycle();
    #1;
    chk("t3_valid", 32'(rsp_valid), 32'h1);
    chk("t3_id",    32'(rsp_id),    32'h0);
    chk("t3_sum",   32'(rsp_sum),   32'h3FFF);
    chk("t3_cout",  32'(rsp_cout),  32'h1);
    cycle();

    // T4: all requesters valid continuously after reset -> strict rotation.
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
    keep_valid = 1'b1;
    obs_ids.delete();
    repeat (14) cycle();
    keep_valid = 1'b0;
    req_valid  = '0;
    chk("t4_count", 32'(obs_ids.size() >= 6), 32'h1);
    for (int k = 0; k < 6; k++) begin
      chk("t4_order", (k < obs_ids.size()) ? 32'(obs_ids[k]) : 32'hDEAD, 32'(exp_seq[k]));
    end
    repeat (3) cycle();

    // T5: backpressure for five cycles with requester 2 waiting.
    set_req(1, rand_op(), rand_op(), 1'b0);
    cycle();
    cycle();
    rsp_ready = 1'b0;
    set_req(2, rand_op(), rand_op(), 1'b1);
    repeat (5) begin
      cycle();
      chk("t5_ready_held", 32'(ready_seen), 32'h0);
    end
    rsp_ready = 1'b1;
    cycle();
    chk("t5_release", 32'(ready_seen), 32'h4);
    repeat (3) cycle();

    // T6: reset while an operation is in CALC.
    set_req(3, rand_op(), rand_op(), 1'b1);
    cycle();
    rst_n = 1'b0;
    set_req(0, rand_op(), rand_op(), 1'b0);
    set_req(2, rand_op(), rand_op(), 1'b1);
    cycle();
    rst_n = 1'b1;
    #1;
    chk("t6_no_rsp", 32'(rsp_valid), 32'h0);
    cycle();
    chk("t6_regrant", 32'(ready_seen), 32'h1);
    repeat (6) cycle();

    // Random traffic with backpressure, drops and occasional reset.
    repeat (400) begin
      rand_inputs();
      cycle();
    end

    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
